// File: rtl/waterfall_light_axil.sv
// waterfall_light_axil: AXI4-Lite programmable running-light generator (rotate / ping-pong / static).
// Optional build macro WFL_IRQ_EN adds CTRL.IRQ_EN and a registered wrap interrupt on irq.
module waterfall_light_axil #(
  parameter int LED_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 32,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [LED_WIDTH-1:0]  led,
  output logic                  irq
);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_PING   = 2'd2;
  localparam logic [1:0] MODE_STATIC = 2'd3;

  localparam int STEP_W = $clog2(LED_WIDTH);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LED_WIDTH - 1);

`ifdef WFL_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  logic                    wr_rdy;
  logic                    bvalid_r;
  logic                    ar_rdy;
  logic                    rvalid_r;
  logic [31:0]             rdata_r;
  logic [3:0]              ctrl;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] presc;
  logic [PERIOD_WIDTH-1:0] period_last;
  logic [31:0]             pattern;
  logic                    wrap;
  logic [STEP_W-1:0]       step_cnt;
  logic                    dir_down;
  logic [LED_WIDTH-1:0]    led_r;

  logic                    en;
  logic [1:0]              mode;
  logic                    wr_fire;
  logic                    wr_ctrl;
  logic                    wr_period;
  logic                    wr_pattern;
  logic                    wr_status;
  logic [3:0]              ctrl_new;
  logic [31:0]             pattern_new;
  logic [PERIOD_WIDTH-1:0] period_new;
  logic                    reload;
  logic [LED_WIDTH-1:0]    reload_val;
  logic                    tc;
  logic                    step;
  logic                    step_wrap;
  logic [LED_WIDTH-1:0]    led_rol;
  logic [LED_WIDTH-1:0]    led_ror;
  logic [LED_WIDTH-1:0]    led_next;
  logic                    dir_next;
  logic [31:0]             rd_val;
  logic                    unused_inputs;

  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR, ARADDR};

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];

  assign AWREADY = wr_rdy;
  assign WREADY  = wr_rdy;
  assign BVALID  = bvalid_r;
  assign BRESP   = 2'b00;
  assign ARREADY = ar_rdy;
  assign RVALID  = rvalid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = 2'b00;
  assign led     = led_r;

  assign wr_fire    = wr_rdy & AWVALID & WVALID;
  assign wr_ctrl    = wr_fire && (AWADDR[3:2] == ADDR_CTRL);
  assign wr_period  = wr_fire && (AWADDR[3:2] == ADDR_PERIOD);
  assign wr_pattern = wr_fire && (AWADDR[3:2] == ADDR_PATTERN);
  assign wr_status  = wr_fire && (AWADDR[3:2] == ADDR_STATUS);

  assign ctrl_new    = WSTRB[0] ? (WDATA[3:0] & CTRL_MASK) : ctrl;
  assign pattern_new = merge_bytes(pattern, WDATA, WSTRB);
  assign period_new  = PERIOD_WIDTH'(merge_bytes(32'(period), WDATA, WSTRB));

  // A pattern write or a mode change restarts the sequence from the pattern.
  assign reload     = wr_pattern || (wr_ctrl && (ctrl_new[2:1] != mode));
  assign reload_val = wr_pattern ? pattern_new[LED_WIDTH-1:0] : pattern[LED_WIDTH-1:0];

  // >= rather than == so a PERIOD lowered below the running count steps at once.
  assign period_last = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
  assign tc          = presc >= period_last;
  assign step        = en && tc && (mode != MODE_STATIC) && !reload;
  assign step_wrap   = step && (step_cnt == STEP_LAST);

  assign led_rol = {led_r[LED_WIDTH-2:0], led_r[LED_WIDTH-1]};
  assign led_ror = {led_r[0], led_r[LED_WIDTH-1:1]};

  always_comb begin
    led_next = led_r;
    dir_next = dir_down;
    case (mode)
      MODE_ROL: led_next = led_rol;
      MODE_ROR: led_next = led_ror;
      MODE_PING: begin
        if (!dir_down) begin
          if (led_r[LED_WIDTH-1]) begin
            led_next = led_ror;
            dir_next = 1'b1;
          end else begin
            led_next = led_rol;
          end
        end else begin
          if (led_r[0]) begin
            led_next = led_rol;
            dir_next = 1'b0;
          end else begin
            led_next = led_ror;
          end
        end
      end
      default: led_next = led_r;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (ARADDR[3:2])
      ADDR_CTRL:    rd_val = 32'(ctrl);
      ADDR_PERIOD:  rd_val = 32'(period);
      ADDR_PATTERN: rd_val = pattern;
      default:      rd_val = (32'(led_r) << 8) | 32'(wrap);
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_rdy   <= 1'b0;
      bvalid_r <= 1'b0;
    end else begin
      wr_rdy <= !wr_rdy && AWVALID && WVALID && !bvalid_r;
      if (wr_fire)                 bvalid_r <= 1'b1;
      else if (bvalid_r && BREADY) bvalid_r <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_rdy   <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      ar_rdy <= !ar_rdy && ARVALID && !rvalid_r;
      if (ar_rdy && ARVALID) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_val;
      end else if (rvalid_r && RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl     <= '0;
      period   <= '0;
      pattern  <= 32'd1;
      wrap     <= 1'b0;
      led_r    <= LED_WIDTH'(1);
      presc    <= '0;
      step_cnt <= '0;
      dir_down <= 1'b0;
    end else begin
      if (wr_ctrl)    ctrl    <= ctrl_new;
      if (wr_period)  period  <= period_new;
      if (wr_pattern) pattern <= pattern_new;

      // A wrap on the same edge as a W1C clear wins.
      if (step_wrap)                            wrap <= 1'b1;
      else if (wr_status && WSTRB[0] && WDATA[0]) wrap <= 1'b0;

      if (reload) begin
        led_r    <= reload_val;
        presc    <= '0;
        step_cnt <= '0;
        dir_down <= 1'b0;
      end else if (en) begin
        if (tc) begin
          presc <= '0;
          if (step) begin
            led_r    <= led_next;
            dir_down <= dir_next;
            step_cnt <= step_wrap ? '0 : step_cnt + STEP_W'(1);
          end
        end else begin
          presc <= presc + PERIOD_WIDTH'(1);
        end
      end else begin
        presc <= '0;
      end
    end
  end

`ifdef WFL_IRQ_EN
  logic irq_r;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) irq_r <= 1'b0;
    else          irq_r <= wrap & ctrl[3];
  end
  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_waterfall_light_axil.sv
// Directed self-checking bench for waterfall_light_axil (default parameters).
module tb_waterfall_light_axil;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  waterfall_light_axil dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .led(led), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  // Write handshakes are counted half a cycle before the edge that takes them.
  always @(negedge ACLK) begin
    if (AWREADY && AWVALID && WREADY && WVALID) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_wready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AWREADY && WREADY) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bvalid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (BVALID) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Returns one cycle after the handshake edge, +1 ns.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit seen;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    wait_wready(seen);
    chk("wr_ready", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_bvalid(seen);
    chk("wr_bvalid", 32'(seen), 32'd1);
    chk("wr_bresp", 32'(BRESP), 32'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit seen;
    ARADDR = addr; ARVALID = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (ARREADY) begin seen = 1'b1; break; end
    end
    chk("rd_arready", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    seen = 1'b0;
    data = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (RVALID) begin seen = 1'b1; data = RDATA; break; end
    end
    chk("rd_rvalid", 32'(seen), 32'd1);
    chk("rd_rresp", 32'(RRESP), 32'd0);
    @(posedge ACLK); #1;
  endtask

  logic [7:0] pp_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    logic [31:0] rd;
    bit seen;
    int early, bv, aw, hs_base;

    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;
    #22 ARESETN = 1'b1;
    tick(1);

    // Reset values
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    axi_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); chk("rst_period", rd, 32'h0);
    axi_read(4'h8, rd); chk("rst_pattern", rd, 32'h1);
    axi_read(4'hC, rd); chk("rst_status", rd, 32'h100);

    // Rotate left, PERIOD=4
    axi_write(4'h8, 32'h01, 4'hF);
    axi_write(4'h4, 32'h04, 4'hF);
    axi_write(4'h0, 32'h01, 4'hF);
    tick(2); chk("rol_c3", 32'(led), 32'h01);
    tick(1); chk("rol_c4", 32'(led), 32'h02);
    tick(24); chk("rol_c28", 32'(led), 32'h80);
    tick(3); chk("rol_c31", 32'(led), 32'h80);
    tick(1); chk("rol_c32", 32'(led), 32'h01);
    axi_read(4'hC, rd); chk("rol_wrap_status", rd, 32'h101);

    // Ping-pong, PERIOD=0
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h4, 32'h00, 4'hF);
    axi_write(4'h8, 32'h01, 4'hF);
    axi_write(4'h0, 32'h05, 4'hF);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("ping_%0d", i), 32'(led), 32'(pp_exp[i]));
      tick(1);
    end

    // WRAP write-one-to-clear
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'hC, 32'h00, 4'hF);
    axi_read(4'hC, rd); chk("w1c_zero_keeps", rd & 32'h1, 32'h1);
    axi_write(4'hC, 32'h01, 4'h1);
    axi_read(4'hC, rd); chk("w1c_clears", rd & 32'h1, 32'h0);

    // W1C landing on the wrap edge: set wins
    axi_write(4'h8, 32'h01, 4'hF);
    axi_write(4'h0, 32'h01, 4'hF);
    tick(5);
    axi_write(4'hC, 32'h01, 4'hF);
    axi_read(4'hC, rd); chk("w1c_vs_wrap", rd & 32'h1, 32'h1);
    axi_write(4'h0, 32'h09, 4'hF);
`ifdef WFL_IRQ_EN
    chk("irq_level", 32'(irq), 32'd1);
    axi_read(4'h0, rd); chk("ctrl_irq_en", rd, 32'h9);
`else
    chk("irq_tied", 32'(irq), 32'd0);
    axi_read(4'h0, rd); chk("ctrl_irq_en", rd, 32'h1);
`endif

    // Rotate right from a mode change
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h8, 32'h01, 4'hF);
    axi_write(4'h0, 32'h03, 4'hF);
    chk("ror_1", 32'(led), 32'h80);
    tick(1); chk("ror_2", 32'(led), 32'h40);

    // Static mode and byte strobes
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h8, 32'hA5, 4'hF);
    axi_write(4'h0, 32'h07, 4'hF);
    chk("static_1", 32'(led), 32'hA5);
    tick(5); chk("static_6", 32'(led), 32'hA5);
    axi_write(4'h8, 32'hFFFF_FF3C, 4'b0010);
    axi_read(4'h8, rd); chk("strb_pattern", rd, 32'h0000_FFA5);
    chk("strb_led", 32'(led), 32'hA5);
    axi_write(4'hC, 32'h01, 4'hF);
    axi_read(4'hC, rd); chk("status_led_field", rd, 32'h0000_A500);

    // Lowering PERIOD below the running count forces a step
    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h8, 32'h01, 4'hF);
    axi_write(4'h4, 32'd100, 4'hF);
    axi_write(4'h0, 32'h01, 4'hF);
    tick(19); chk("per_before", 32'(led), 32'h01);
    axi_write(4'h4, 32'd5, 4'hF);
    chk("per_forced", 32'(led), 32'h02);
    tick(4); chk("per_c5", 32'(led), 32'h02);
    tick(1); chk("per_c6", 32'(led), 32'h04);

    // W ahead of AW, stalled B channel
    axi_write(4'h0, 32'h00, 4'hF);
    hs_base = hs_cnt;
    BREADY = 1'b0;
    AWADDR = 4'h4; WDATA = 32'h33; WSTRB = 4'hF; WVALID = 1'b1;
    early = 0;
    repeat (3) begin
      @(negedge ACLK);
      if (WREADY || AWREADY) early++;
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b1;
    wait_wready(seen); chk("wfirst_hs", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wfirst_early_rdy", 32'(early), 32'd0);
    WDATA = 32'h55; AWVALID = 1'b1; WVALID = 1'b1;
    bv = 0; aw = 0;
    repeat (5) begin
      @(negedge ACLK);
      bv += int'(BVALID);
      aw += int'(AWREADY);
    end
    chk("bstall_bvalid_cycles", 32'(bv), 32'd5);
    chk("bstall_no_accept", 32'(aw), 32'd0);
    chk("bstall_hs_once", 32'(hs_cnt - hs_base), 32'd1);
    BREADY = 1'b1;
    wait_wready(seen); chk("second_hs", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_bvalid(seen); chk("second_bvalid", 32'(seen), 32'd1);
    tick(1);
    chk("hs_total", 32'(hs_cnt - hs_base), 32'd2);
    axi_read(4'h4, rd); chk("period_final", rd, 32'h55);

    // Reset while a write response is pending
    BREADY = 1'b0;
    AWADDR = 4'h8; WDATA = 32'h10; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    wait_wready(seen); chk("rst_wr_hs", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("rst_b_pending", 32'(BVALID), 32'd1);
    chk("rst_led_before", 32'(led), 32'h10);
    ARESETN = 1'b0;
    #1;
    chk("rst_b_dropped", 32'(BVALID), 32'd0);
    chk("rst_led_async", 32'(led), 32'h01);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    BREADY = 1'b1;
    bv = 0;
    repeat (5) begin
      @(negedge ACLK);
      bv += int'(BVALID);
    end
    chk("rst_no_late_b", 32'(bv), 32'd0);
    chk("rst_led_after", 32'(led), 32'h01);
    tick(1);
    axi_read(4'h8, rd); chk("rst_pattern_after", rd, 32'h1);
    chk("irq_final", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/waterfall_light_axil.md
WATERFALL_LIGHT_AXIL -- requirements
Module: waterfall_light_axil

Interface
REQ-001 SHALL have parameter LED_WIDTH, default 8, number of LED outputs (legal 2..32).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 32, width of step-period register and prescaler.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, AXI4-Lite byte address width (register map 0x00-0x0C).
REQ-004 SHALL have ports: ACLK  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: ARESETN  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: AWADDR in ADDR_WIDTH; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1  write address channel.
REQ-007 SHALL have ports: WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1  write data channel.
REQ-008 SHALL have ports: BRESP out 2; BVALID out 1; BREADY in 1  write response channel.
REQ-009 SHALL have ports: ARADDR in ADDR_WIDTH; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1  read address channel.
REQ-010 SHALL have ports: RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1  read data channel.
REQ-011 SHALL have ports: led  out  LED_WIDTH  current light pattern.
REQ-012 SHALL have ports: irq  out  1  wrap interrupt (see Configuration).

Function
REQ-013 SHALL decode AWADDR[3:2]/ARADDR[3:2]: 0x00 CTRL {bit0 EN, bits2:1 MODE, bit3 IRQ_EN}; 0x04 PERIOD; 0x08 PATTERN; 0x0C STATUS {bit0 WRAP (W1C), bits LED_WIDTH+7:8 led (RO)}.
REQ-014 SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID and WVALID are both high and BVALID is low; AW/W arriving in either order wait for each other.
REQ-015 SHALL update the addressed register on the AW/W handshake edge, byte-masked by WSTRB, unwritten bits read as 0.
REQ-016 SHALL assert BVALID with BRESP=OKAY the cycle after the write handshake and hold it until BREADY; no new write accepted while BVALID high.
REQ-017 SHALL assert ARREADY for one cycle when ARVALID high and RVALID low; RVALID with RDATA/RRESP=OKAY the next cycle, held stable until RREADY.
REQ-018 SHALL run the prescaler 0..max(PERIOD,1)-1 while EN=1; a step occurs on terminal count; PERIOD=0 steps every cycle.
REQ-019 SHALL step led per MODE: 0 rotate left, 1 rotate right, 2 ping-pong (rotate toward MSB until led[LED_WIDTH-1]=1, then toward LSB until led[0]=1, reverse), 3 static (led=PATTERN, no steps).
REQ-020 SHALL load led from PATTERN[LED_WIDTH-1:0] and clear prescaler, step counter and ping-pong direction (toward MSB) on any PATTERN write or MODE change.
REQ-021 SHALL, with EN=0, hold led and prescaler at current/zero respectively.
REQ-022 SHALL count steps 0..LED_WIDTH-1; step count wrap sets WRAP=1 in the same edge.
REQ-023 SHALL give set priority to WRAP when a W1C write and a wrap event coincide.
REQ-024 SHALL apply a CTRL/PERIOD write to the prescaler from the next cycle; a write lowering PERIOD below current count forces a step on the next cycle.

Reset
REQ-025 SHALL, on ARESETN low, asynchronously clear all AXI ready/valid outputs, BRESP, RRESP, RDATA, CTRL, PERIOD, STATUS, prescaler, step counter; PATTERN and led reset to 1 (LSB lit); irq 0.
REQ-026 SHALL abandon any in-flight transaction when reset asserts mid-operation; no response issued after release.

Configuration
REQ-027 SHALL, with WFL_IRQ_EN defined, drive irq = WRAP & IRQ_EN registered (one cycle after WRAP sets) and level-held until WRAP cleared.
REQ-028 SHALL, without WFL_IRQ_EN, tie irq to 0, read CTRL bit3 as 0, and still implement WRAP in STATUS.

Verification
REQ-029 SHALL cover: reset release, read all four registers -> 0x0, 0x0, 0x1, 0x100 (LED_WIDTH=8).
REQ-030 SHALL cover: PATTERN=0x01, PERIOD=4, CTRL=0x1 -> led 0x02 after 4 cycles, 0x80 after 28, 0x01 after 32 with WRAP=1.
REQ-031 SHALL cover: MODE=2, PATTERN=0x01, PERIOD=0 -> led sequence 0x01,0x02..0x80,0x40..0x01 one per cycle.
REQ-032 SHALL cover: W before AW by 3 cycles, BREADY low 5 cycles -> single handshake, BVALID held 5 cycles, register updated once.
REQ-033 SHALL cover: write STATUS=0x1 on the wrap edge -> WRAP reads 1; with WFL_IRQ_EN and IRQ_EN=1, irq high one cycle later.
REQ-034 SHALL cover: ARESETN low while BVALID pending -> BVALID 0 immediately, led=0x01 after release.
